// File: rtl/alu_op_scheduler.sv
// alu_op_scheduler
//   Round-robin front-end that shares one combinational ALU/FPU datapath
//   between NREQ requesters. A granted request's operands are registered
//   onto the datapath inputs. The result is sampled one cycle later and
//   returned with the requester index over a valid/ready response channel.
//   One operation is in flight at a time: IDLE -> EXEC -> RESP -> IDLE.
//
// Parameters
//   NREQ  : number of requesters (2..8)
//   WIDTH : operand/result width
//   IDW   : requester ID width, 2**IDW >= NREQ
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready : per-requester handshake (req_ready one-hot or zero)
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_sel             : packed op selects, requester i at [i*2 +: 2]
//   alu_a/alu_b/alu_sel : registered datapath inputs
//   alu_y               : combinational datapath result
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_y        : requester index and captured result
//
// Optional build macro ALU_SCHED_STATS_EN adds:
//   stat_ops   : saturating count of completed response handshakes
//   stat_stall : saturating count of RESP cycles with rsp_ready low

module alu_op_scheduler #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*2-1:0]     req_sel,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [1:0]            alu_sel,
  input  logic [WIDTH-1:0]      alu_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_y
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_stall
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_sel_q, alu_sel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   cand;

  // Round-robin search starting just after the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr_q) + 32'd1 + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_IDLE && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          alu_a_d   = req_a[gnt_idx*WIDTH +: WIDTH];
          alu_b_d   = req_b[gnt_idx*WIDTH +: WIDTH];
          alu_sel_d = req_sel[gnt_idx*2 +: 2];
          rsp_id_d  = gnt_idx;
          ptr_d     = gnt_idx;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_y_d     = alu_y;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  always_comb begin
    stat_ops_d   = stat_ops_q;
    stat_stall_d = stat_stall_q;
    if (state_q == ST_RESP) begin
      if (rsp_ready) begin
        if (stat_ops_q != '1) stat_ops_d = stat_ops_q + 16'd1;
      end else begin
        if (stat_stall_q != '1) stat_stall_d = stat_stall_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q   <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_ops_q   <= stat_ops_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_ops   = stat_ops_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed bench for alu_op_scheduler with a scoreboard: every grant pushes
// the expected response, every response handshake pops and compares it.
module tb_alu_op_scheduler;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*2-1:0]     req_sel;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [1:0]            alu_sel;
  logic [WIDTH-1:0]      alu_y;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_y;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0]           stat_ops;
  logic [15:0]           stat_stall;
`endif

  always #5 clk = ~clk;

  alu_op_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_y(rsp_y)
`ifdef ALU_SCHED_STATS_EN
    , .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
  );

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] sel);
    case (sel)
      2'b00:   alu_model = a + b;
      2'b01:   alu_model = a - b;
      2'b10:   alu_model = a & b;
      2'b11:   alu_model = a | b;
      default: alu_model = 8'h00;
    endcase
  endfunction

  assign alu_y = alu_model(alu_a, alu_b, alu_sel);

  typedef struct {
    logic [1:0] id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
    logic [7:0] y;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];
  int   grant_cyc[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  logic rsp_valid_prev = 1'b0;
  exp_t mon_e;
  int   mon_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic neg();
    @(negedge clk);
    #1;
  endtask

  // Monitor: grants push expectations, response handshakes pop them.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      rsp_valid_prev = 1'b0;
    end else begin
      if (req_valid != '0) chk("onehot", 32'($onehot0(req_ready)), 32'd1);
      if (req_ready != '0) begin
        mon_id = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_id = i;
        mon_e.id  = mon_id[1:0];
        mon_e.a   = req_a[mon_id*8 +: 8];
        mon_e.b   = req_b[mon_id*8 +: 8];
        mon_e.sel = req_sel[mon_id*2 +: 2];
        mon_e.y   = alu_model(mon_e.a, mon_e.b, mon_e.sel);
        exp_q.push_back(mon_e);
        grant_log.push_back(mon_id);
        grant_cyc.push_back(cyc);
        acc_cyc = cyc;
      end
      if (rsp_valid && !rsp_valid_prev) chk("latency", 32'(cyc - acc_cyc), 32'd2);
      if (rsp_valid && rsp_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("sb_rsp_id", 32'(rsp_id), 32'(mon_e.id));
          chk("sb_rsp_y", 32'(rsp_y), 32'(mon_e.y));
          chk("sb_alu_a", 32'(alu_a), 32'(mon_e.a));
          chk("sb_alu_b", 32'(alu_b), 32'(mon_e.b));
          chk("sb_alu_sel", 32'(alu_sel), 32'(mon_e.sel));
        end
      end
      rsp_valid_prev = rsp_valid;
    end
  end

  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 30 && (exp_q.size() != 0 || rsp_valid); k++) neg();
    chk(tag, 32'(exp_q.size() == 0 && !rsp_valid), 32'd1);
  endtask

  task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] sel, input logic [7:0] exp_y, input string tag);
    int k;
    @(posedge clk); #1;
    req_a[i*8 +: 8]   = a;
    req_b[i*8 +: 8]   = b;
    req_sel[i*2 +: 2] = sel;
    req_valid[i[1:0]] = 1'b1;
    for (k = 0; k < 20 && !req_ready[i[1:0]]; k++) neg();
    chk({tag, "_grant"}, 32'(req_ready[i[1:0]]), 32'd1);
    @(posedge clk); #1;
    req_valid[i[1:0]] = 1'b0;
    for (k = 0; k < 10 && !rsp_valid; k++) neg();
    chk({tag, "_y"}, 32'(rsp_y), 32'(exp_y));
    chk({tag, "_id"}, 32'(rsp_id), 32'(i));
    for (k = 0; k < 20 && rsp_valid; k++) neg();
    chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int   k;
    int   base;
    logic [1:0]  xs;
    logic [15:0] s0;
    logic [15:0] o0;
    s0 = '0;
    o0 = '0;
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_sel = '0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_sel", 32'(alu_sel), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single requester, all four ops
    issue(0, 8'h0C, 8'h03, 2'b00, 8'h0F, "add");
    issue(0, 8'h0C, 8'h03, 2'b01, 8'h09, "sub");
    issue(0, 8'h0C, 8'h03, 2'b10, 8'h00, "and");
    issue(0, 8'h0C, 8'h03, 2'b11, 8'h0F, "or");
    issue(3, 8'hFF, 8'hFF, 2'b11, 8'hFF, "or_ff");

    // All requesters continuously valid: 0,1,2,3,0,... every 3 cycles
    base = grant_log.size();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*8 +: 8]   = 8'(8'h10 + 8'(i * 17));
      req_b[i*8 +: 8]   = 8'(i + 1);
      req_sel[i*2 +: 2] = 2'(i);
    end
    req_valid = '1;
    for (k = 0; k < 60 && grant_log.size() < base + 8; k++) neg();
    @(posedge clk); #1;
    req_valid = '0;
    chk("rr_count", 32'(grant_log.size() >= base + 8), 32'd1);
    if (grant_log.size() >= base + 8) begin
      for (int j = 0; j < 8; j++) begin
        chk("rr_order", 32'(grant_log[base + j]), 32'(j % 4));
        if (j > 0) chk("rr_spacing", 32'(grant_cyc[base + j] - grant_cyc[base + j - 1]), 32'd3);
      end
    end
    drain("rr_drain");

    // Requesters 1 and 3 after a grant to 3: 1 then 3
    base = grant_log.size();
    @(posedge clk); #1;
    req_valid = 4'b1010;
    for (k = 0; k < 30 && grant_log.size() < base + 2; k++) neg();
    @(posedge clk); #1;
    req_valid = '0;
    chk("p13_count", 32'(grant_log.size() >= base + 2), 32'd1);
    if (grant_log.size() >= base + 2) begin
      chk("p13_first", 32'(grant_log[base]), 32'd1);
      chk("p13_second", 32'(grant_log[base + 1]), 32'd3);
    end
    drain("p13_drain");

    // Response stall for 5 RESP cycles; requester 2 waits meanwhile
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_a[7:0] = 8'h55; req_b[7:0] = 8'h0F; req_sel[1:0] = 2'b10;
    req_valid = 4'b0101;
    for (k = 0; k < 20 && !req_ready[0]; k++) neg();
    chk("stall_grant0", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    for (k = 0; k < 10 && !rsp_valid; k++) neg();
    chk("stall_rsp_y0", 32'(rsp_y), 32'h05);
`ifdef ALU_SCHED_STATS_EN
    s0 = stat_stall;
    o0 = stat_ops;
`endif
    for (int j = 0; j < 5; j++) begin
      if (j == 4) begin
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        neg();
      end else begin
        neg();
      end
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_y", 32'(rsp_y), 32'h05);
      chk("stall_id", 32'(rsp_id), 32'd0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
`ifdef ALU_SCHED_STATS_EN
    chk("stat_stall", 32'(stat_stall), 32'(s0 + 16'd5));
`endif
    neg();
    chk("stall_released", 32'(rsp_valid), 32'd0);
`ifdef ALU_SCHED_STATS_EN
    chk("stat_ops", 32'(stat_ops), 32'(o0 + 16'd1));
`endif
    for (k = 0; k < 20 && !req_ready[2]; k++) neg();
    chk("stall_grant2", 32'(req_ready[2]), 32'd1);
    @(posedge clk); #1;
    req_valid = '0;
    drain("stall_drain");

    // Asynchronous reset during EXEC
    @(posedge clk); #1;
    req_a[15:8] = 8'h11; req_b[15:8] = 8'h22; req_sel[3:2] = 2'b00;
    req_valid[1] = 1'b1;
    for (k = 0; k < 20 && !req_ready[1]; k++) neg();
    chk("rstx_grant1", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rstx_valid", 32'(rsp_valid), 32'd0);
    chk("rstx_alu_a", 32'(alu_a), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      neg();
      chk("rstx_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 4'b0101;
    for (k = 0; k < 20 && req_ready == '0; k++) neg();
    chk("rstx_first_grant", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    drain("rstx_drain");

    // Unknown select is forwarded untouched, then the block keeps working
    @(posedge clk); #1;
    req_a[23:16] = 8'h3C; req_b[23:16] = 8'h0F; req_sel[5:4] = 2'bxx;
    xs = req_sel[5:4];
    req_valid[2] = 1'b1;
    for (k = 0; k < 20 && !req_ready[2]; k++) neg();
    chk("x_grant", 32'(req_ready[2]), 32'd1);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    for (k = 0; k < 10 && !rsp_valid; k++) neg();
    chk("x_alu_sel", 32'(alu_sel), 32'(xs));
    chk("x_rsp_id", 32'(rsp_id), 32'd2);
    drain("x_drain");
    issue(0, 8'h01, 8'h02, 2'b00, 8'h03, "after_x");

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
